// File: rtl/plate_pkg.sv
// Shared result-word types for the plate recognition datapath
// (OCR stage, result mailbox, HPS bridge).
package plate_pkg;

  localparam int unsigned RESULT_W = 64;

  typedef logic [RESULT_W-1:0] result_t;

endpackage

// File: rtl/plate_result_mailbox_if.sv
// Result mailbox bus: upstream result handshake plus the HPS-facing read,
// flush and event signals.
interface plate_result_mailbox_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 16
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              hps_pop;
  logic              hps_flush;
  logic [DATA_W-1:0] hps_rd_data;
  logic              hps_empty;
  logic [CW-1:0]     hps_count;
  logic              event_ready;

  modport master (
    output res_valid, res_data, hps_pop, hps_flush,
    input  res_ready, hps_rd_data, hps_empty, hps_count, event_ready
  );

  modport slave (
    input  res_valid, res_data, hps_pop, hps_flush,
    output res_ready, hps_rd_data, hps_empty, hps_count, event_ready
  );

endinterface

// File: rtl/mailbox_fifo.sv
// Register-array FIFO with show-ahead head, occupancy count and synchronous flush.
// Exposes the next-state count so the owner can clamp its own bookkeeping.
module mailbox_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [CW-1:0]     count,
  output logic [CW-1:0]     count_next,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              push_en, pop_en;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_en = push & ~full & ~flush;
  assign pop_en  = pop & ~empty & ~flush;

  always_comb begin
    count_next = count_q;
    if (flush) begin
      count_next = '0;
    end else if (push_en && !pop_en) begin
      count_next = count_q + CW'(1);
    end else if (pop_en && !push_en) begin
      count_next = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_next;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_q] <= wr_data;
  end

  // Storage is not reset, so mask the head while empty to present zero.
  assign rd_data = empty ? '0 : mem[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/plate_result_mailbox.sv
// Plate result mailbox: buffers OCR results for the HPS and emits a coalesced
// single-cycle event pulse on a pending-count threshold or a wait timeout.
module plate_result_mailbox
  import plate_pkg::*;
#(
  parameter int unsigned DATA_W       = RESULT_W,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned COALESCE_CNT = 4,
  parameter int unsigned TIMEOUT_CYC  = 1000000
) (
  input logic                   clk,
  input logic                   reset,
  plate_result_mailbox_if.slave mbx
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;

  logic [CW-1:0] count, count_next;
  logic          full, empty;
  logic          push_acc;

  logic [CW-1:0] pending_q, pending_d, pending_inc, pending_next;
  logic [TW-1:0] timer_q, timer_d;
  logic          event_q, fire;

  mailbox_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (mbx.res_valid),
    .pop        (mbx.hps_pop),
    .flush      (mbx.hps_flush),
    .wr_data    (mbx.res_data),
    .rd_data    (mbx.hps_rd_data),
    .count      (count),
    .count_next (count_next),
    .full       (full),
    .empty      (empty)
  );

  assign push_acc = mbx.res_valid & ~full;

  always_comb begin
    pending_inc = pending_q;
    if (push_acc && pending_q != CW'(DEPTH)) pending_inc = pending_q + CW'(1);

    // Results the HPS already polled away must not be signalled.
    pending_next = (pending_inc > count_next) ? count_next : pending_inc;
    if (mbx.hps_flush) pending_next = '0;

    fire = !mbx.hps_flush &&
           ((pending_next >= CW'(COALESCE_CNT)) ||
            (pending_next != '0 && timer_q == TW'(TIMEOUT_CYC - 1)));

    pending_d = fire ? '0 : pending_next;
    timer_d   = (fire || pending_next == '0) ? '0 : timer_q + TW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      timer_q   <= '0;
      event_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      timer_q   <= timer_d;
      event_q   <= fire;
    end
  end

  assign mbx.res_ready   = ~full;
  assign mbx.hps_empty   = empty;
  assign mbx.hps_count   = count;
  assign mbx.event_ready = event_q;

endmodule

// File: tb/tb_plate_result_mailbox.sv
// Self-checking bench for plate_result_mailbox: hand vectors, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_plate_result_mailbox;
  import plate_pkg::*;

  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CC    = 4;
  localparam int unsigned T     = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  plate_result_mailbox_if #(.DATA_W(DW), .DEPTH(DEPTH)) mbx ();

  plate_result_mailbox #(
    .DATA_W       (DW),
    .DEPTH        (DEPTH),
    .COALESCE_CNT (CC),
    .TIMEOUT_CYC  (T)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mbx   (mbx)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: stored words as a queue, pending/timer as plain integers.
  result_t m_q[$];
  int      m_pend, m_tmr;
  bit      m_ev;

  task automatic model_reset();
    m_q.delete();
    m_pend = 0;
    m_tmr  = 0;
    m_ev   = 0;
  endtask

  task automatic model_step(input bit v, input result_t d, input bit p, input bit f);
    bit push, popd, fire;
    int pn;
    if (f) begin
      model_reset();
      return;
    end
    push = v && (m_q.size() < DEPTH);
    popd = p && (m_q.size() > 0);
    if (popd) void'(m_q.pop_front());
    if (push) m_q.push_back(d);
    pn = m_pend + (push ? 1 : 0);
    if (pn > DEPTH) pn = DEPTH;
    if (pn > m_q.size()) pn = m_q.size();
    fire = (pn >= CC) || (pn > 0 && m_tmr == T - 1);
    m_ev = fire;
    if (fire) begin
      m_pend = 0;
      m_tmr  = 0;
    end else begin
      m_pend = pn;
      m_tmr  = (pn == 0) ? 0 : m_tmr + 1;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    result_t head;
    head = (m_q.size() == 0) ? '0 : m_q[0];
    chk("res_ready", 64'(mbx.res_ready), 64'(m_q.size() < DEPTH));
    chk("hps_empty", 64'(mbx.hps_empty), 64'(m_q.size() == 0));
    chk("hps_count", 64'(mbx.hps_count), 64'(m_q.size()));
    chk("hps_rd_data", mbx.hps_rd_data, head);
    chk("event_ready", 64'(mbx.event_ready), 64'(m_ev));
  endtask

  // One clock: drive, model the edge, then compare 1 time unit after it.
  task automatic cycle(input bit v, input result_t d, input bit p, input bit f);
    mbx.res_valid = v;
    mbx.res_data  = d;
    mbx.hps_pop   = p;
    mbx.hps_flush = f;
    @(posedge clk);
    model_step(v, d, p, f);
    #1;
    check_model();
  endtask

  task automatic idle(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b0);
      if (mbx.event_ready) pulses++;
    end
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    mbx.res_valid = 1'b0;
    mbx.res_data  = '0;
    mbx.hps_pop   = 1'b0;
    mbx.hps_flush = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_model();
    reset = 1'b0;
  endtask

  typedef struct {
    logic    v;
    result_t d;
    logic    p;
    logic    f;
    int      exp_cnt;
    logic    exp_ev;
    logic    exp_empty;
    result_t exp_rd;
  } vec_t;

  vec_t tbl[9];

  initial begin
    result_t a, b, c, d, e, w;
    int      pulses, edge_idx;
    bit      seen;

    a = 64'h4142_4331_3233_3435;
    b = 64'h4B4C_4D39_3837_3635;
    c = 64'h5859_5A30_3030_3031;
    d = 64'h4445_4632_3232_3232;
    e = 64'h5041_5241_4D45_5445;

    // Four back-to-back pushes coalesce into one pulse after the 4th edge.
    tbl[0] = '{1'b1, a,   1'b0, 1'b0, 1, 1'b0, 1'b0, a};
    tbl[1] = '{1'b1, b,   1'b0, 1'b0, 2, 1'b0, 1'b0, a};
    tbl[2] = '{1'b1, c,   1'b0, 1'b0, 3, 1'b0, 1'b0, a};
    tbl[3] = '{1'b1, d,   1'b0, 1'b0, 4, 1'b1, 1'b0, a};
    tbl[4] = '{1'b0, '0,  1'b0, 1'b0, 4, 1'b0, 1'b0, a};
    tbl[5] = '{1'b0, '0,  1'b1, 1'b0, 3, 1'b0, 1'b0, b};
    tbl[6] = '{1'b1, e,   1'b1, 1'b0, 3, 1'b0, 1'b0, c};
    tbl[7] = '{1'b1, a,   1'b0, 1'b1, 0, 1'b0, 1'b1, '0};
    tbl[8] = '{1'b0, '0,  1'b1, 1'b0, 0, 1'b0, 1'b1, '0};

    do_reset();
    chk("reset_ready", 64'(mbx.res_ready), 64'd1);
    chk("reset_count", 64'(mbx.hps_count), 64'd0);
    chk("reset_rd", mbx.hps_rd_data, 64'd0);

    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].p, tbl[i].f);
      chk($sformatf("tbl%0d_count", i), 64'(mbx.hps_count), 64'(tbl[i].exp_cnt));
      chk($sformatf("tbl%0d_event", i), 64'(mbx.event_ready), 64'(tbl[i].exp_ev));
      chk($sformatf("tbl%0d_empty", i), 64'(mbx.hps_empty), 64'(tbl[i].exp_empty));
      chk($sformatf("tbl%0d_rd", i), mbx.hps_rd_data, tbl[i].exp_rd);
    end

    // Timeout: 3 pending results, pulse after edge T-1 counted from the first push.
    do_reset();
    cycle(1'b1, a, 1'b0, 1'b0);
    cycle(1'b1, b, 1'b0, 1'b0);
    cycle(1'b1, c, 1'b0, 1'b0);
    chk("to_count", 64'(mbx.hps_count), 64'd3);
    chk("to_head", mbx.hps_rd_data, a);
    seen = 0;
    edge_idx = -1;
    for (int e_i = 3; e_i < 3 * T && !seen; e_i++) begin
      cycle(1'b0, '0, 1'b0, 1'b0);
      if (mbx.event_ready) begin
        seen = 1;
        edge_idx = e_i;
      end
    end
    chk("to_pulse_seen", 64'(seen), 64'd1);
    chk("to_pulse_edge", 64'(edge_idx), 64'(T - 1));
    idle(T + 4, pulses);
    chk("to_no_retrigger", 64'(pulses), 64'd0);

    // Fill to DEPTH, refused push, pop+valid while full pops only, then refill.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 64'(i + 100), 1'b0, 1'b0);
    chk("full_ready", 64'(mbx.res_ready), 64'd0);
    cycle(1'b1, 64'hDEAD, 1'b0, 1'b0);
    chk("full_refuse", 64'(mbx.hps_count), 64'(DEPTH));
    cycle(1'b1, 64'hBEEF, 1'b1, 1'b0);
    chk("full_pop_only", 64'(mbx.hps_count), 64'(DEPTH - 1));
    chk("full_pop_head", mbx.hps_rd_data, 64'd101);
    cycle(1'b1, 64'hCAFE, 1'b0, 1'b0);
    chk("full_refill", 64'(mbx.hps_count), 64'(DEPTH));

    // Polled away before timeout: no event at all.
    do_reset();
    cycle(1'b1, a, 1'b0, 1'b0);
    cycle(1'b1, b, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    idle(2 * T, pulses);
    chk("poll_no_event", 64'(pulses), 64'd0);
    chk("poll_empty", 64'(mbx.hps_empty), 64'd1);

    // Pointer wrap with one entry in flight.
    do_reset();
    cycle(1'b1, 64'h5700, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) begin
      w = 64'h5700 + 64'(i);
      cycle(1'b1, w, 1'b1, 1'b0);
      chk($sformatf("wrap%0d_head", i), mbx.hps_rd_data, w);
      chk($sformatf("wrap%0d_count", i), 64'(mbx.hps_count), 64'd1);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("wrap_empty", 64'(mbx.hps_empty), 64'd1);

    // Flush with 5 stored and a simultaneous push.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 64'(i + 1), 1'b0, 1'b0);
    cycle(1'b1, 64'h77, 1'b0, 1'b1);
    chk("flush_count", 64'(mbx.hps_count), 64'd0);
    chk("flush_empty", 64'(mbx.hps_empty), 64'd1);
    chk("flush_event", 64'(mbx.event_ready), 64'd0);
    idle(2 * T, pulses);
    chk("flush_no_event", 64'(pulses), 64'd0);

    // Asynchronous reset in the middle of a timeout wait.
    do_reset();
    cycle(1'b1, a, 1'b0, 1'b0);
    idle(5, pulses);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    chk("areset_ready", 64'(mbx.res_ready), 64'd1);
    chk("areset_count", 64'(mbx.hps_count), 64'd0);
    chk("areset_event", 64'(mbx.event_ready), 64'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    idle(T + 4, pulses);
    chk("areset_no_pulse", 64'(pulses), 64'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 9) < 6, {$urandom, $urandom}, $urandom_range(0, 9) < 4,
            $urandom_range(0, 63) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
